gpu_instr_dispatcher: RTL and testbench

Host-side issue engine for the GPU execution core. Buffers 32-bit instructions from a command source in a small FIFO and drives the core's single-outstanding instruction handshake (valid/ready, with the instruction held through the core's decode cycle). Captures each core result and returns it in order with a sequence tag. A watchdog flags a core that never completes.

---
 rtl/gpu_pkg.sv | 36 +++
 rtl/gpu_cmd_fifo.sv | 56 +++++
 rtl/gpu_instr_dispatcher.sv | 155 +++++++++++++++
 tb/tb_gpu_instr_dispatcher.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared types and constants for the GPU instruction dispatcher
// Purpose: data width, opcode encoding, instruction field positions and the
// dispatcher state encoding used by gpu_instr_dispatcher and its helpers.
package gpu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4
  } gpu_opcode_e;

  // Instruction word layout
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 28;
  localparam int DEST_MSB = 27;
  localparam int DEST_LSB = 23;
  localparam int SRC1_MSB = 22;
  localparam int SRC1_LSB = 18;
  localparam int SRC2_MSB = 17;
  localparam int SRC2_LSB = 13;
  localparam int IMM_MSB  = 12;
  localparam int IMM_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD,
    ST_WAIT,
    ST_RESP
  } disp_state_e;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// rtl/gpu_cmd_fifo.sv - synchronous instruction FIFO for the dispatcher
// Purpose: buffers command words between the command source and the issue FSM.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata     write request and data (ignored when full)
//   pop, rdata      read request (ignored when empty); rdata shows the head
//   full, empty     occupancy flags
//   count           number of stored entries (0..DEPTH)
module gpu_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gpu_instr_dispatcher.sv
// rtl/gpu_instr_dispatcher.sv - issues queued instructions to the GPU core one at a time
// Purpose: buffers commands, drives the core's valid/ready handshake with the
// instruction held through the core's decode cycle, returns results in order
// with a sequence tag, and aborts a core that never completes.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   cmd_valid, cmd_data, cmd_ready    command stream into the FIFO
//   core_valid, core_instr            instruction to the core
//   core_ready, core_result           core idle flag and result
//   res_valid, res_data, res_tag,
//   res_timeout, res_ready            result stream back to the host
//   busy, fifo_count                  activity and queue occupancy
//   err_timeout, clear_err            sticky watchdog error and its clear
module gpu_instr_dispatcher import gpu_pkg::*; #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64,
  parameter int DATA_W     = 32,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready,
  output logic              core_valid,
  output logic [DATA_W-1:0] core_instr,
  input  logic              core_ready,
  input  logic [DATA_W-1:0] core_result,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [7:0]        res_tag,
  output logic              res_timeout,
  input  logic              res_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              err_timeout,
  input  logic              clear_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  disp_state_e       state;
  logic [WD_W-1:0]   wd_cnt;
  logic [7:0]        tag_q;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              wd_expired;

  gpu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .wdata (cmd_data),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cmd_ready  = !fifo_full;
  assign busy       = (state != ST_IDLE) || !fifo_empty;
  assign res_tag    = tag_q;
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));

  // The head is taken from IDLE, or straight from RESP once the result is
  // accepted so the next issue follows without an idle bubble.
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) || (state == ST_RESP && res_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wd_cnt      <= '0;
      tag_q       <= '0;
      core_valid  <= 1'b0;
      core_instr  <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_timeout <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      // A watchdog abort below overrides a same-cycle clear.
      if (clear_err) err_timeout <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            core_instr <= fifo_head;
            core_valid <= 1'b1;
            wd_cnt     <= '0;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (core_ready) begin
            core_valid <= 1'b0;
            state      <= ST_HOLD;
          end else if (wd_expired) begin
            core_valid  <= 1'b0;
            res_data    <= '0;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            err_timeout <= 1'b1;
            state       <= ST_RESP;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        ST_HOLD: begin
          // core_instr stays put while the core decodes it.
          wd_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_ready) begin
            res_data    <= core_result;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state       <= ST_RESP;
          end else if (wd_expired) begin
            res_data    <= '0;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            err_timeout <= 1'b1;
            state       <= ST_RESP;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            tag_q     <= tag_q + 8'd1;
            if (fifo_pop) begin
              core_instr <= fifo_head;
              core_valid <= 1'b1;
              wd_cnt     <= '0;
              state      <= ST_ISSUE;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_instr_dispatcher.sv
// tb/tb_gpu_instr_dispatcher.sv - directed self-checking bench for gpu_instr_dispatcher
module tb_gpu_instr_dispatcher;

  localparam logic [31:0] KEY = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic        core_valid;
  logic [31:0] core_instr;
  logic        core_ready;
  logic [31:0] core_result;
  logic        res_valid;
  logic [31:0] res_data;
  logic [7:0]  res_tag;
  logic        res_timeout;
  logic        res_ready;
  logic        busy;
  logic [3:0]  fifo_count;
  logic        err_timeout;
  logic        clear_err;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_tag;
  logic        core_hang;
  logic [31:0] core_lat;
  logic [1:0]  core_cnt;

  gpu_instr_dispatcher #(
    .FIFO_DEPTH (8),
    .TIMEOUT    (64),
    .DATA_W     (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .core_valid  (core_valid),
    .core_instr  (core_instr),
    .core_ready  (core_ready),
    .core_result (core_result),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_tag     (res_tag),
    .res_timeout (res_timeout),
    .res_ready   (res_ready),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .err_timeout (err_timeout),
    .clear_err   (clear_err)
  );

  always #5 clk = ~clk;

  // Core model: drops ready on accepting an instruction, raises it again
  // three cycles after the decode cycle with result = KEY ^ low byte.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_ready  <= 1'b1;
      core_result <= '0;
      core_lat    <= '0;
      core_cnt    <= '0;
    end else if (core_ready && core_valid) begin
      core_ready <= 1'b0;
      core_lat   <= core_instr;
      core_cnt   <= 2'd3;
    end else if (!core_ready && !core_hang) begin
      if (core_cnt == 2'd1) begin
        core_ready  <= 1'b1;
        core_result <= KEY ^ {24'h0, core_lat[7:0]};
      end
      core_cnt <= core_cnt - 2'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    while (!cmd_ready && n < 200) begin
      step();
      n++;
    end
    check("push_accept", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res();
    int n = 0;
    while (!res_valid && n < 200) begin
      step();
      n++;
    end
    check("res_wait", 32'(res_valid), 32'd1);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    exp_tag = exp_tag + 8'd1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core_valid"}, 32'(core_valid), 32'd0);
    check({tag, "_core_instr"}, core_instr, 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"}, res_data, 32'd0);
    check({tag, "_res_tag"}, 32'(res_tag), 32'd0);
    check({tag, "_res_timeout"}, 32'(res_timeout), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
    check({tag, "_err"}, 32'(err_timeout), 32'd0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = '0;
    res_ready = 1'b0;
    clear_err = 1'b0;
    core_hang = 1'b0;
    exp_tag = 8'd0;

    // Reset state
    step();
    step();
    check_reset_outputs("rst0");
    rst = 1'b0;
    step();

    // Single ADD instruction with cycle-exact handshake timing
    cmd_valid = 1'b1;
    cmd_data  = 32'h0088_0000;
    step();
    cmd_valid = 1'b0;
    check("t1_count1", 32'(fifo_count), 32'd1);
    check("t1_valid_pre", 32'(core_valid), 32'd0);
    step();
    check("t1_issue_valid", 32'(core_valid), 32'd1);
    check("t1_issue_instr", core_instr, 32'h0088_0000);
    check("t1_busy", 32'(busy), 32'd1);
    step();
    check("t1_hold_valid", 32'(core_valid), 32'd0);
    check("t1_hold_instr", core_instr, 32'h0088_0000);
    step();
    step();
    step();
    check("t1_wait_last", 32'(res_valid), 32'd0);
    step();
    check("t1_res_valid", 32'(res_valid), 32'd1);
    check("t1_res_data", res_data, 32'h1234_5678);
    check("t1_res_tag", 32'(res_tag), 32'd0);
    check("t1_res_timeout", 32'(res_timeout), 32'd0);

    // Stall in RESP with a second command queued
    push(32'h1000_0002);
    for (int i = 0; i < 10; i++) begin
      check("t3_stall_valid", 32'(res_valid), 32'd1);
      check("t3_stall_data", res_data, 32'h1234_5678);
      check("t3_stall_core_valid", 32'(core_valid), 32'd0);
      check("t3_stall_count", 32'(fifo_count), 32'd1);
      step();
    end
    accept();
    check("t3_next_issue", 32'(core_valid), 32'd1);
    check("t3_next_instr", core_instr, 32'h1000_0002);
    check("t3_res_drop", 32'(res_valid), 32'd0);
    check("t3_count0", 32'(fifo_count), 32'd0);
    wait_res();
    check("t3_res_data", res_data, 32'h1234_567A);
    check("t3_res_tag", 32'(res_tag), 32'(exp_tag));
    accept();
    step();

    // Fill: one in flight plus a full FIFO, then drain in order
    for (int i = 0; i < 9; i++) push(32'h2000_0020 + i);
    check("t2_full_ready", 32'(cmd_ready), 32'd0);
    check("t2_full_count", 32'(fifo_count), 32'd8);
    cmd_valid = 1'b1;
    cmd_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_overflow_count", 32'(fifo_count), 32'd8);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wait_res();
      check("t2_order_data", res_data, KEY ^ (32'h20 + 32'(i)));
      check("t2_order_tag", 32'(res_tag), 32'(exp_tag));
      accept();
    end
    step();
    check("t2_idle", 32'(busy), 32'd0);

    // Watchdog: core never returns to ready after decode
    core_hang = 1'b1;
    push(32'h3000_0055);
    step();
    check("t4_issue", 32'(core_valid), 32'd1);
    step();
    for (int i = 0; i < 64; i++) step();
    check("t4_last_wait", 32'(res_valid), 32'd0);
    step();
    check("t4_res_valid", 32'(res_valid), 32'd1);
    check("t4_res_data", res_data, 32'd0);
    check("t4_res_timeout", 32'(res_timeout), 32'd1);
    check("t4_err", 32'(err_timeout), 32'd1);
    check("t4_tag", 32'(res_tag), 32'(exp_tag));
    accept();
    step();
    step();
    check("t4_err_sticky", 32'(err_timeout), 32'd1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("t4_err_cleared", 32'(err_timeout), 32'd0);

    // Revive the core (shared reset), then reset mid-WAIT with 3 queued
    core_hang = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_tag = 8'd0;
    step();
    push(32'h4000_0001);
    push(32'h4000_0002);
    push(32'h4000_0003);
    push(32'h4000_0004);
    check("t5_wait_count", 32'(fifo_count), 32'd3);
    check("t5_wait_core_valid", 32'(core_valid), 32'd0);
    check("t5_wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    check_reset_outputs("t5");
    rst = 1'b0;
    exp_tag = 8'd0;
    step();
    step();
    check("t5_stays_idle", 32'(busy), 32'd0);

    // 257 instructions: tags 0..255 then wrap to 0
    for (int i = 0; i < 257; i++) begin
      push(32'h4000_0000 | 32'(i[7:0]));
      wait_res();
      check("t6_tag", 32'(res_tag), 32'(exp_tag));
      check("t6_data", res_data, KEY ^ 32'(i[7:0]));
      accept();
    end
    check("t6_tag_wrapped", 32'(res_tag), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
